smaesh_core_arbiter: RTL and testbench

- Shares one masked AES core (SVRS input/output handshakes) between two requesters.
- Each requester carries a shared plaintext/ciphertext, a shared key, and the mode flags `inverse` and `key_schedule_only`.
- Round-robin grant; exactly one operation in flight; the response is routed back to the requester that issued it.
- Sits between the top-level request ports and the core; all randomness handling stays inside the core.

---
 rtl/smaesh_core_arbiter_if.sv | 55 +++++
 rtl/smaesh_core_arbiter.sv | 64 ++++++
 tb/tb_smaesh_core_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/smaesh_core_arbiter_if.sv
// smaesh_core_arbiter_if: request, response and core-side handshake bundle for smaesh_core_arbiter
//   req0_*/req1_* : sticky requests (valid, ready, data, key, inverse, ks_only)
//   rsp0_*/rsp1_* : responses (valid, ready, data)
//   core_*        : masked AES core input/output handshakes, data and mode flags
//   slave modport faces the arbiter, master modport faces requesters and core
interface smaesh_core_arbiter_if #(
    parameter int DATA_W = 256,
    parameter int KEY_W  = 256
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [KEY_W-1:0]  req0_key;
    logic              req0_inverse;
    logic              req0_ks_only;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [KEY_W-1:0]  req1_key;
    logic              req1_inverse;
    logic              req1_ks_only;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;
    logic              core_valid_in;
    logic              core_in_ready;
    logic [DATA_W-1:0] core_data_in;
    logic [KEY_W-1:0]  core_key_in;
    logic              core_inverse;
    logic              core_ks_only;
    logic              core_cipher_valid;
    logic              core_out_ready;
    logic [DATA_W-1:0] core_data_out;
    modport slave (
        input  req0_valid, req0_data, req0_key, req0_inverse, req0_ks_only,
        input  req1_valid, req1_data, req1_key, req1_inverse, req1_ks_only,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  rsp0_ready, rsp1_ready,
        output core_valid_in, core_data_in, core_key_in, core_inverse, core_ks_only, core_out_ready,
        input  core_in_ready, core_cipher_valid, core_data_out
    );
    modport master (
        output req0_valid, req0_data, req0_key, req0_inverse, req0_ks_only,
        output req1_valid, req1_data, req1_key, req1_inverse, req1_ks_only,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output rsp0_ready, rsp1_ready,
        input  core_valid_in, core_data_in, core_key_in, core_inverse, core_ks_only, core_out_ready,
        output core_in_ready, core_cipher_valid, core_data_out
    );
endinterface

// File: rtl/smaesh_core_arbiter.sv
// smaesh_core_arbiter: round-robin sharing of one masked AES core between two requesters
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response/core handshakes (smaesh_core_arbiter_if.slave)
//   grant_id : current/last granted requester
//   busy     : high whenever an operation is being arbitrated, issued or delivered
module smaesh_core_arbiter #(
    parameter int DATA_W = 256,
    parameter int KEY_W  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    smaesh_core_arbiter_if.slave   bus,
    output logic                   grant_id,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_OUT, DELIVER} state_t;
    state_t state, state_d;
    logic   grant_d, ptr, ptr_d, issue, out_phase, done;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= 1'b0;
            ptr      <= 1'b0;
        end else begin
            state    <= state_d;
            grant_id <= grant_d;
            ptr      <= ptr_d;
        end
    end
    always_comb begin
        state_d   = state;
        grant_d   = grant_id;
        ptr_d     = ptr;
        issue     = state == ISSUE;
        out_phase = state == WAIT_OUT || state == DELIVER;
        done      = out_phase && bus.core_cipher_valid && bus.core_out_ready;
        case (state)
            IDLE: begin
                // pointer only breaks ties; a sole requester wins regardless
                grant_d = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
                state_d = (bus.req0_valid || bus.req1_valid) ? ISSUE : IDLE;
                if (!(bus.req0_valid || bus.req1_valid)) grant_d = grant_id;
            end
            ISSUE:    state_d = bus.core_in_ready ? WAIT_OUT : ISSUE;
            WAIT_OUT: state_d = done ? IDLE : bus.core_cipher_valid ? DELIVER : WAIT_OUT;
            DELIVER:  state_d = done ? IDLE : DELIVER;
        endcase
        ptr_d = done ? ~grant_id : ptr;
        busy = state != IDLE;
        bus.core_valid_in = issue;
        bus.core_data_in  = issue ? (grant_id ? bus.req1_data : bus.req0_data) : {DATA_W{1'b0}};
        bus.core_key_in   = issue ? (grant_id ? bus.req1_key : bus.req0_key) : {KEY_W{1'b0}};
        bus.core_inverse  = issue && (grant_id ? bus.req1_inverse : bus.req0_inverse);
        bus.core_ks_only  = issue && (grant_id ? bus.req1_ks_only : bus.req0_ks_only);
        // accept pulses depend only on state, grant and the core, never on req valid
        bus.req0_ready = issue && bus.core_in_ready && !grant_id;
        bus.req1_ready = issue && bus.core_in_ready && grant_id;
        bus.core_out_ready = out_phase && (grant_id ? bus.rsp1_ready : bus.rsp0_ready);
        bus.rsp0_valid = out_phase && !grant_id && bus.core_cipher_valid;
        bus.rsp1_valid = out_phase && grant_id && bus.core_cipher_valid;
        bus.rsp0_data  = (out_phase && !grant_id) ? bus.core_data_out : {DATA_W{1'b0}};
        bus.rsp1_data  = (out_phase && grant_id) ? bus.core_data_out : {DATA_W{1'b0}};
    end
endmodule

// File: tb/tb_smaesh_core_arbiter.sv
// tb_smaesh_core_arbiter: directed self-checking bench for smaesh_core_arbiter
module tb_smaesh_core_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant_id, busy;
  int checks = 0;
  int failures = 0;
  smaesh_core_arbiter_if bus ();
  smaesh_core_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy));
  always #5 clk = ~clk;
  localparam logic [255:0] D0 = {248'h0, 8'hA5};
  localparam logic [255:0] D1 = {8{32'h1357_9BDF}};
  localparam logic [255:0] K0 = {8{32'h0F0F_1234}};
  localparam logic [255:0] K1 = {8{32'hC0DE_5A5A}};
  localparam logic [255:0] R0 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] R1 = {8{32'h0BAD_F00D}};
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic g, input logic [255:0] d, input logic [255:0] k,
                        input logic inv, input logic ks, input logic [255:0] rv);
    tick();
    chk("op_grant", grant_id, g);
    chk("op_core_valid_in", bus.core_valid_in, 1'b1);
    chk("op_core_data_in", bus.core_data_in, d);
    chk("op_core_key_in", bus.core_key_in, k);
    chk("op_core_inverse", bus.core_inverse, inv);
    chk("op_core_ks_only", bus.core_ks_only, ks);
    bus.core_in_ready = 1'b1;
    #1;
    chk("op_req0_ready", bus.req0_ready, !g);
    chk("op_req1_ready", bus.req1_ready, g);
    tick();
    bus.core_in_ready = 1'b0;
    bus.core_cipher_valid = 1'b1;
    bus.core_data_out = rv;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    chk("op_core_valid_in_off", bus.core_valid_in, 1'b0);
    chk("op_core_data_in_off", bus.core_data_in, 256'h0);
    chk("op_rsp0_valid", bus.rsp0_valid, !g);
    chk("op_rsp1_valid", bus.rsp1_valid, g);
    chk("op_rsp0_data", bus.rsp0_data, g ? 256'h0 : rv);
    chk("op_rsp1_data", bus.rsp1_data, g ? rv : 256'h0);
    chk("op_core_out_ready", bus.core_out_ready, 1'b1);
    tick();
    bus.core_cipher_valid = 1'b0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    chk("op_idle_busy", busy, 1'b0);
    chk("op_idle_core_inverse", bus.core_inverse, 1'b0);
  endtask
  initial begin
    bus.req0_valid = 0; bus.req0_data = D0; bus.req0_key = K0; bus.req0_inverse = 0; bus.req0_ks_only = 0;
    bus.req1_valid = 0; bus.req1_data = D1; bus.req1_key = K1; bus.req1_inverse = 0; bus.req1_ks_only = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    bus.core_in_ready = 0; bus.core_cipher_valid = 0; bus.core_data_out = '0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_core_valid_in", bus.core_valid_in, 1'b0);
    chk("rst_core_data_in", bus.core_data_in, 256'h0);
    chk("rst_core_key_in", bus.core_key_in, 256'h0);
    chk("rst_core_out_ready", bus.core_out_ready, 1'b0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    chk("rst_req0_ready", bus.req0_ready, 1'b0);
    rst = 1'b0;
    tick();
    bus.req0_valid = 1'b1;
    #1;
    chk("t1_idle_req0_ready", bus.req0_ready, 1'b0);
    tick();
    chk("t1_grant", grant_id, 1'b0);
    chk("t1_core_valid_in", bus.core_valid_in, 1'b1);
    chk("t1_core_data_in", bus.core_data_in, D0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_no_ready_yet", bus.req0_ready, 1'b0);
    tick();
    chk("t1_still_issue", bus.core_valid_in, 1'b1);
    bus.core_in_ready = 1'b1;
    #1;
    chk("t1_req0_ready", bus.req0_ready, 1'b1);
    chk("t1_req1_ready", bus.req1_ready, 1'b0);
    tick();
    bus.core_in_ready = 1'b0;
    bus.req0_valid = 1'b0;
    #1;
    chk("t1_wait_valid_in", bus.core_valid_in, 1'b0);
    chk("t1_wait_data_in", bus.core_data_in, 256'h0);
    chk("t1_wait_req0_ready", bus.req0_ready, 1'b0);
    chk("t1_wait_rsp0_valid", bus.rsp0_valid, 1'b0);
    bus.core_cipher_valid = 1'b1;
    bus.core_data_out = R0;
    #1;
    chk("t1_rsp0_valid", bus.rsp0_valid, 1'b1);
    chk("t1_rsp0_data", bus.rsp0_data, R0);
    chk("t1_rsp1_valid", bus.rsp1_valid, 1'b0);
    chk("t1_rsp1_data", bus.rsp1_data, 256'h0);
    chk("t1_out_ready_low", bus.core_out_ready, 1'b0);
    tick();
    chk("t1_deliver_busy", busy, 1'b1);
    chk("t1_deliver_rsp0_valid", bus.rsp0_valid, 1'b1);
    bus.rsp0_ready = 1'b1;
    #1;
    chk("t1_out_ready_high", bus.core_out_ready, 1'b1);
    tick();
    bus.core_cipher_valid = 1'b0;
    bus.rsp0_ready = 1'b0;
    #1;
    chk("t1_done_busy", busy, 1'b0);
    chk("t1_done_rsp0_valid", bus.rsp0_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    run_op(1'b0, D0, K0, 1'b0, 1'b0, R0);
    run_op(1'b1, D1, K1, 1'b0, 1'b0, R1);
    run_op(1'b0, D0, K0, 1'b0, 1'b0, R0);
    run_op(1'b1, D1, K1, 1'b0, 1'b0, R1);
    bus.req0_valid = 1'b0;
    tick();
    chk("bp_grant", grant_id, 1'b1);
    bus.core_in_ready = 1'b1;
    tick();
    bus.core_in_ready = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.core_cipher_valid = 1'b1;
    bus.core_data_out = R1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_out_ready", bus.core_out_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
      chk("bp_req0_ready", bus.req0_ready, 1'b0);
      chk("bp_rsp1_valid", bus.rsp1_valid, 1'b1);
    end
    bus.rsp1_ready = 1'b1;
    #1;
    chk("bp_release", bus.core_out_ready, 1'b1);
    tick();
    bus.core_cipher_valid = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    chk("bp_idle", busy, 1'b0);
    run_op(1'b0, D0, K0, 1'b0, 1'b0, R0);
    bus.req1_inverse = 1'b1;
    bus.req1_ks_only = 1'b1;
    bus.req1_valid = 1'b1;
    run_op(1'b1, D1, K1, 1'b1, 1'b1, R1);
    run_op(1'b0, D0, K0, 1'b0, 1'b0, R0);
    tick();
    chk("st_grant_first", grant_id, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = ~bus.req0_valid;
      tick();
      chk("st_data", bus.core_data_in, D1);
      chk("st_key", bus.core_key_in, K1);
      chk("st_grant", grant_id, 1'b1);
      chk("st_req0_ready", bus.req0_ready, 1'b0);
    end
    bus.core_in_ready = 1'b1;
    #1;
    chk("st_req1_ready", bus.req1_ready, 1'b1);
    chk("st_req0_ready_end", bus.req0_ready, 1'b0);
    tick();
    bus.core_in_ready = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.core_cipher_valid = 1'b1;
    bus.rsp1_ready = 1'b1;
    tick();
    bus.core_cipher_valid = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    chk("st_idle", busy, 1'b0);
    bus.req1_valid = 1'b1;
    tick();
    chk("rm_grant", grant_id, 1'b1);
    bus.core_in_ready = 1'b1;
    tick();
    bus.core_in_ready = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.core_cipher_valid = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    chk("rm_busy", busy, 1'b0);
    chk("rm_grant_zero", grant_id, 1'b0);
    chk("rm_rsp1_valid", bus.rsp1_valid, 1'b0);
    chk("rm_out_ready", bus.core_out_ready, 1'b0);
    chk("rm_core_valid_in", bus.core_valid_in, 1'b0);
    chk("rm_req1_ready", bus.req1_ready, 1'b0);
    bus.core_cipher_valid = 1'b0;
    bus.rsp1_ready = 1'b0;
    bus.req1_valid = 1'b1;
    run_op(1'b1, D1, K1, 1'b1, 1'b1, R1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
